// File: rtl/mprj_checkpoint_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mprj_checkpoint_monitor
// Purpose  : Watches the mprj_io checkbits/status nibble and steps through a
//            programmable table of checkpoints. Each checkpoint is a masked
//            compare against the synchronized {io_status, io_check} value that
//            must hold for STABLE consecutive cycles. The run ends in PASS
//            when the final checkpoint is met, or in FAIL when a single step
//            exceeds timeout_lim cycles.
// Ports    : wb_clk_i/wb_rst_i  clock, synchronous active-high reset
//            io_check/io_status asynchronous observation inputs
//            cfg_*              checkpoint table write port (ignored while busy)
//            timeout_lim        per-step cycle limit, 0 disables the timeout
//            start              run request (ignored while busy)
//            busy/pass/fail     run status (pass/fail sticky until next start)
//            step               current or terminal checkpoint index
//            matched            one-cycle pulse per accepted checkpoint
// Revision : 1.0 - initial release
// ============================================================================
module mprj_checkpoint_monitor #(
    parameter int DEPTH  = 8,
    parameter int TO_W   = 24,
    parameter int STABLE = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [15:0]              io_check,
    input  logic [3:0]               io_status,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [19:0]              cfg_val,
    input  logic [19:0]              cfg_mask,
    input  logic                     cfg_last,
    input  logic [TO_W-1:0]          timeout_lim,
    input  logic                     start,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [$clog2(DEPTH)-1:0] step,
    output logic                     matched
);

    localparam int c_aw = $clog2(DEPTH);
    // STABLE is at most 15, so a 4-bit streak counter always suffices.
    localparam int c_sw = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [19:0]      sync1_q;
    logic [19:0]      sync2_q;

    logic [19:0]      val_q  [DEPTH];
    logic [19:0]      mask_q [DEPTH];
    logic [DEPTH-1:0] last_q;

    state_t           state_q;
    logic             busy_q;
    logic             pass_q;
    logic             fail_q;
    logic             matched_q;
    logic [c_aw-1:0]  step_q;
    logic [TO_W-1:0]  timer_q;
    logic [c_sw-1:0]  stable_q;

    // Next-state candidates and decode
    logic [c_sw-1:0]  stable_d;
    logic [TO_W-1:0]  timer_d;
    logic             w_match;
    logic             w_accept;
    logic             w_timeout;
    logic             w_final;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the whole 20-bit observation word. The
    // stable-count requirement downstream filters any cycle where the
    // individual bits resolved inconsistently.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 20'd0;
            sync2_q <= 20'd0;
        end else begin
            sync1_q <= {io_status, io_check};
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Checkpoint table. Reset leaves every entry as "don't care, final",
    // so a run on an unprogrammed table passes at step 0. Writes during a
    // run are dropped so the table cannot change under the comparator.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i]  <= 20'd0;
                mask_q[i] <= 20'd0;
            end
            last_q <= '1;
        end else if (cfg_we && (state_q != ST_WAIT)) begin
            val_q[cfg_addr]  <= cfg_val;
            mask_q[cfg_addr] <= cfg_mask;
            last_q[cfg_addr] <= cfg_last;
        end
    end

    // ------------------------------------------------------------------
    // Compare and step decode
    // ------------------------------------------------------------------
    assign w_match   = (((sync2_q ^ val_q[step_q]) & mask_q[step_q]) == 20'd0);
    assign stable_d  = stable_q + c_sw'(1);
    // Accept on the cycle that delivers the STABLE-th consecutive match.
    assign w_accept  = w_match && (stable_d == c_sw'(STABLE));
    assign w_timeout = (timeout_lim != '0) && (timer_q == timeout_lim);
    assign w_final   = last_q[step_q] || (step_q == c_aw'(DEPTH - 1));
    // Saturating increment: the timer parks at all-ones rather than wrapping.
    assign timer_d   = (timer_q == '1) ? timer_q : (timer_q + TO_W'(1));

    // ------------------------------------------------------------------
    // Run controller
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            matched_q <= 1'b0;
            step_q    <= '0;
            timer_q   <= '0;
            stable_q  <= '0;
        end else begin
            matched_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        state_q  <= ST_WAIT;
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        fail_q   <= 1'b0;
                        step_q   <= '0;
                        timer_q  <= '0;
                        stable_q <= '0;
                    end
                end
                ST_WAIT: begin
                    // Acceptance is checked before the timeout so that a
                    // checkpoint met on the limit cycle still counts.
                    if (w_accept) begin
                        matched_q <= 1'b1;
                        stable_q  <= '0;
                        timer_q   <= '0;
                        if (w_final) begin
                            state_q <= ST_PASS;
                            busy_q  <= 1'b0;
                            pass_q  <= 1'b1;
                        end else begin
                            step_q <= step_q + c_aw'(1);
                        end
                    end else if (w_timeout) begin
                        state_q <= ST_FAIL;
                        busy_q  <= 1'b0;
                        fail_q  <= 1'b1;
                    end else begin
                        timer_q  <= timer_d;
                        stable_q <= w_match ? stable_d : '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign step    = step_q;
    assign matched = matched_q;

endmodule
`default_nettype wire

// File: tb/tb_mprj_checkpoint_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mprj_checkpoint_monitor
// Purpose  : Scoreboard bench for mprj_checkpoint_monitor. A reference model
//            predicts the output word after every clock edge and queues it;
//            a monitor pops and compares on every falling edge. Directed
//            scenarios are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mprj_checkpoint_monitor;

    localparam int DEPTH  = 8;
    localparam int TO_W   = 24;
    localparam int STABLE = 2;
    localparam int AW     = 3;
    localparam int TMAX   = (1 << TO_W) - 1;

    logic            clk;
    logic            rst;
    logic [15:0]     io_check;
    logic [3:0]      io_status;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [19:0]     cfg_val;
    logic [19:0]     cfg_mask;
    logic            cfg_last;
    logic [TO_W-1:0] lim;
    logic            start;
    logic            d_busy;
    logic            d_pass;
    logic            d_fail;
    logic [AW-1:0]   d_step;
    logic            d_matched;

    mprj_checkpoint_monitor #(
        .DEPTH  (DEPTH),
        .TO_W   (TO_W),
        .STABLE (STABLE)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .io_check    (io_check),
        .io_status   (io_status),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_val     (cfg_val),
        .cfg_mask    (cfg_mask),
        .cfg_last    (cfg_last),
        .timeout_lim (lim),
        .start       (start),
        .busy        (d_busy),
        .pass        (d_pass),
        .fail        (d_fail),
        .step        (d_step),
        .matched     (d_matched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_matched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a run is "current index + cycles spent on it +
    // length of the current match streak"; inputs reach the comparator
    // two edges after they are sampled.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          busy;
        logic          pass;
        logic          fail;
        logic [AW-1:0] step;
        logic          matched;
    } exp_t;

    exp_t        sb[$];
    logic [19:0] hist[$];
    logic [19:0] t_val  [DEPTH];
    logic [19:0] t_mask [DEPTH];
    bit          t_last [DEPTH];
    bit          m_running, m_pass, m_fail, m_matched;
    int          m_idx, m_wait, m_streak;
    logic [19:0] m_s;

    function automatic bit entry_matches(input logic [19:0] s, input int idx);
        for (int b = 0; b < 20; b++)
            if (t_mask[idx][b] && (s[b] != t_val[idx][b])) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                t_val[i] = 20'd0; t_mask[i] = 20'd0; t_last[i] = 1'b1;
            end
            m_running = 0; m_pass = 0; m_fail = 0; m_matched = 0;
            m_idx = 0; m_wait = 0; m_streak = 0;
            hist.delete();
            hist.push_back(20'd0);
            hist.push_back(20'd0);
        end else begin
            m_s = hist.pop_front();
            hist.push_back({io_status, io_check});
            m_matched = 0;
            if (!m_running) begin
                if (cfg_we) begin
                    t_val[cfg_addr] = cfg_val; t_mask[cfg_addr] = cfg_mask; t_last[cfg_addr] = cfg_last;
                end
                if (start) begin
                    m_running = 1; m_pass = 0; m_fail = 0;
                    m_idx = 0; m_wait = 0; m_streak = 0;
                end
            end else begin
                m_streak = entry_matches(m_s, m_idx) ? m_streak + 1 : 0;
                if (m_streak == STABLE) begin
                    m_matched = 1;
                    if (t_last[m_idx] || (m_idx == DEPTH - 1)) begin
                        m_running = 0; m_pass = 1;
                    end else begin
                        m_idx++;
                    end
                    m_wait = 0; m_streak = 0;
                end else if ((lim != 0) && (m_wait == int'(lim))) begin
                    m_running = 0; m_fail = 1;
                end else if (m_wait < TMAX) begin
                    m_wait++;
                end
            end
        end
        sb.push_back({m_running, m_pass, m_fail, m_idx[AW-1:0], m_matched});
    end

    // Monitor: the DUT presents a new output word after every edge.
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t a;
        a = {d_busy, d_pass, d_fail, d_step, d_matched};
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got output %0h expected none queued", a);
        end else begin
            e = sb.pop_front();
            check("cycle_outputs", 32'(a), 32'(e));
        end
        check("pass_and_fail", 32'(d_pass & d_fail), 32'd0);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change only just after a falling edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (d_matched) n_matched++;
    endtask

    task automatic write_entry(input int a, input logic [19:0] v, input logic [19:0] m, input logic l);
        cfg_we = 1'b1; cfg_addr = a[AW-1:0]; cfg_val = v; cfg_mask = m; cfg_last = l;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic hold(input logic [3:0] st, input logic [15:0] ck, input int n);
        io_status = st; io_check = ck;
        repeat (n) tick();
    endtask

    // Drives the four-checkpoint sequence, each value held long enough to
    // cover the synchronizer plus the stable streak.
    task automatic run_seq();
        hold(4'h0, 16'hAB40, 5);
        hold(4'hA, 16'hAB40, 5);
        hold(4'h5, 16'hAB40, 5);
        hold(4'h5, 16'hAB51, 5);
    endtask

    initial begin : drv
        int cnt;
        int hold_left;
        logic [19:0] r;
        logic [19:0] masks [6];

        rst = 1'b1; io_check = 16'h0; io_status = 4'h0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_val = 20'h0; cfg_mask = 20'h0; cfg_last = 1'b0; lim = '0; start = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {27'd0, d_busy, d_pass, d_fail, d_matched, d_step == 0 ? 1'b0 : 1'b1}, 32'd0);
        rst = 1'b0;

        // Four-entry table, full sequence
        write_entry(0, 20'h0AB40, 20'h0FFFF, 1'b0);
        write_entry(1, 20'hA0000, 20'hF0000, 1'b0);
        write_entry(2, 20'h50000, 20'hF0000, 1'b0);
        write_entry(3, 20'h0AB51, 20'h0FFFF, 1'b1);
        lim = 24'd1000;
        io_check = 16'h0;
        n_matched = 0;
        do_start();
        run_seq();
        check("seq_matched_count", n_matched, 4);
        check("seq_pass", 32'(d_pass), 1);
        check("seq_step", 32'(d_step), 3);
        check("seq_fail", 32'(d_fail), 0);

        // Writes and start during a run are dropped
        hold(4'h0, 16'h0000, 1);
        do_start();
        write_entry(0, 20'h00000, 20'hFFFFF, 1'b1);
        do_start();
        hold(4'h0, 16'h0000, 4);
        check("busy_drop_step", 32'(d_step), 0);
        check("busy_drop_busy", 32'(d_busy), 1);
        n_matched = 0;
        run_seq();
        check("readback_matched", n_matched, 4);
        check("readback_pass", 32'(d_pass), 1);
        check("readback_step", 32'(d_step), 3);

        // Timeout on a value that never matches
        io_status = 4'h0; io_check = 16'h1968;
        do_start();
        cnt = 0;
        while (!d_fail && cnt < 1100) begin
            tick();
            cnt++;
        end
        check("timeout_cycles", cnt, 1001);
        check("timeout_fail", 32'(d_fail), 1);
        check("timeout_step", 32'(d_step), 0);
        check("timeout_busy", 32'(d_busy), 0);

        // Acceptance on the same edge as the timeout
        lim = 24'd5;
        io_check = 16'h0000;
        do_start();
        tick(); tick();
        io_check = 16'hAB40;
        tick(); tick(); tick();
        check("tie_pre_matched", 32'(d_matched), 0);
        tick();
        check("tie_matched", 32'(d_matched), 1);
        check("tie_step", 32'(d_step), 1);
        check("tie_fail", 32'(d_fail), 0);
        hold(4'h0, 16'h0000, 12);
        check("tie_late_fail", 32'(d_fail), 1);

        // Glitch rejection and exact acceptance latency
        lim = 24'd1000;
        do_start();
        hold(4'h0, 16'h0000, 2);
        hold(4'h0, 16'hAB40, 1);
        hold(4'h0, 16'h0000, 5);
        check("glitch_step", 32'(d_step), 0);
        io_check = 16'hAB40;
        tick();
        tick();
        check("lat_k1", 32'(d_matched), 0);
        tick();
        check("lat_k2", 32'(d_matched), 0);
        tick();
        check("lat_k3", 32'(d_matched), 1);
        check("lat_step", 32'(d_step), 1);

        // Reset mid-run at step 2, then a run on the default table
        rst = 1'b1; tick(); rst = 1'b0;
        write_entry(0, 20'h0AB40, 20'h0FFFF, 1'b0);
        write_entry(1, 20'hA0000, 20'hF0000, 1'b0);
        write_entry(2, 20'h50000, 20'hF0000, 1'b0);
        io_status = 4'h0; io_check = 16'h0000;
        do_start();
        hold(4'h0, 16'hAB40, 5);
        hold(4'hA, 16'hAB40, 5);
        check("pre_reset_step", 32'(d_step), 2);
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", {27'd0, d_busy, d_pass, d_fail, d_matched, d_step != 0}, 32'd0);
        rst = 1'b0;
        io_status = 4'h0; io_check = 16'h0000;
        do_start();
        tick();
        check("default_pass_early", 32'(d_pass), 0);
        tick();
        check("default_pass", 32'(d_pass), 1);
        check("default_step", 32'(d_step), 0);

        // Randomized phase
        masks[0] = 20'h00000; masks[1] = 20'h0000F; masks[2] = 20'hF0000;
        masks[3] = 20'h000FF; masks[4] = 20'h0FFFF; masks[5] = 20'hFFFFF;
        hold_left = 0;
        lim = 24'd20;
        for (int c = 0; c < 4000; c++) begin
            if (hold_left == 0) begin
                r = 20'($urandom);
                if ($urandom_range(0, 3) != 0)
                    r = (t_val[m_idx] & t_mask[m_idx]) | (r & ~t_mask[m_idx]);
                {io_status, io_check} = r;
                hold_left = $urandom_range(1, 5);
            end
            hold_left--;
            rst      = ($urandom_range(0, 199) == 0);
            cfg_we   = ($urandom_range(0, 19) == 0);
            cfg_addr = AW'($urandom_range(0, DEPTH - 1));
            cfg_val  = 20'($urandom);
            cfg_mask = masks[$urandom_range(0, 5)];
            cfg_last = ($urandom_range(0, 3) == 0);
            start    = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 99) == 0)
                lim = ($urandom_range(0, 3) == 0) ? 24'd0 : TO_W'($urandom_range(3, 30));
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0; start = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
